// File: rtl/soc_pkg.sv
//==============================================================================
// Module : soc_pkg
// Brief  : Shared bus-slave constants, UART TX state encoding and a STATUS
//          word packing helper.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package soc_pkg;

  // Register word offsets relative to a slave's base address
  localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

  // STATUS register bit positions
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_W   = 5;

  // Transmitter frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Assemble the STATUS read word; unused bits read as zero
  function automatic logic [31:0] pack_status(
    input logic                      full,
    input logic                      empty,
    input logic                      busy,
    input logic                      ovf,
    input logic [STATUS_COUNT_W-1:0] count
  );
    logic [31:0] v;
    v                                     = '0;
    v[STATUS_FULL_BIT]                    = full;
    v[STATUS_EMPTY_BIT]                   = empty;
    v[STATUS_BUSY_BIT]                    = busy;
    v[STATUS_OVF_BIT]                     = ovf;
    v[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
//==============================================================================
// Module : fifo_sync
// Brief  : Single-clock FIFO with occupancy count. A push into a full FIFO is
//          accepted only when a pop happens on the same edge.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];

  // A pop frees a slot on the same edge, so a full FIFO can still take a push
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage array; contents are don't-care until written so it carries no reset
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_slave.sv
//==============================================================================
// Module : uart_tx_slave
// Brief  : Memory-mapped 8N1 UART transmitter with a small TX FIFO. The core
//          writes bytes to TXDATA and polls STATUS; frames are sent back to
//          back while the FIFO holds data.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_tx_slave
  import soc_pkg::*;
#(
  parameter int          CLKDIV    = 434,
  parameter int          FIFODEPTH = 8,
  parameter logic [31:0] BASEADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] busaddr,
  input  logic [31:0] busdataw,
  input  logic        buswrite,
  output logic [31:0] busdatar,
  output logic        txd
);

  localparam int                CW        = $clog2(FIFODEPTH) + 1;
  localparam int                BAUD_W    = $clog2(CLKDIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKDIV - 1);

  // Bus decode
  logic           w_sel_data;
  logic           w_sel_status;
  logic           w_push;
  logic           w_clr_ovf;

  // FIFO interface
  logic           w_pop;
  logic [7:0]     w_fifo_head;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [CW-1:0]  w_fifo_count;

  // Frame sequencer state
  uart_tx_state_t r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_txd;
  logic           r_ovf;
  logic           w_baud_last;
  logic           w_busy;
  logic           w_unused_wdata;

  assign w_sel_data   = (busaddr == (BASEADDR + UART_TXDATA_OFS));
  assign w_sel_status = (busaddr == (BASEADDR + UART_STATUS_OFS));
  assign w_push       = buswrite && w_sel_data;
  assign w_clr_ovf    = buswrite && w_sel_status && busdataw[STATUS_OVF_BIT];

  // Upper write-data bits carry no meaning for either register
  assign w_unused_wdata = &{1'b0, busdataw[31:8]};

  assign w_baud_last  = (r_baud == BAUD_LAST);
  assign w_busy       = (r_state != IDLE);

  // The sequencer takes the FIFO head when idle or when a stop bit completes
  assign w_pop = !w_fifo_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_baud_last));

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (nrst),
    .i_push  (w_push),
    .i_wdata (busdataw[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Frame sequencer: baud timing, bit shifting and the registered serial line
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd  <= 1'b1;
          r_baud <= '0;
          if (!w_fifo_empty) begin
            r_shift <= w_fifo_head;
            r_state <= START;
            r_txd   <= 1'b0;
          end
        end

        START: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
            r_txd     <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            // Chain straight into the next start bit when data is waiting
            if (!w_fifo_empty) begin
              r_shift <= w_fifo_head;
              r_state <= START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_baud  <= '0;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped push on the same edge as a clear keeps it set
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_fifo_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign txd = r_txd;

  // Read mux: only STATUS returns data, every other address reads zero
  always_comb begin
    busdatar = '0;
    if (w_sel_status) begin
      busdatar = pack_status(w_fifo_full, w_fifo_empty, w_busy, r_ovf,
                             STATUS_COUNT_W'(w_fifo_count));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_slave.sv
//==============================================================================
// Module : tb_uart_tx_slave
// Brief  : Self-checking bench for uart_tx_slave. A serial monitor decodes
//          frames on txd and compares them with bytes queued at write time.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_slave;

  localparam int          CLKDIV    = 4;
  localparam int          FIFODEPTH = 4;
  localparam logic [31:0] BASEADDR  = 32'h100;
  localparam int          FRAME     = 10 * CLKDIV;
  localparam logic [31:0] STATUS_A  = BASEADDR + 32'h4;

  logic        clk      = 1'b0;
  logic        nrst     = 1'b0;
  logic [31:0] busaddr  = 32'h0;
  logic [31:0] busdataw = 32'h0;
  logic        buswrite = 1'b0;
  logic [31:0] busdatar;
  logic        txd;

  int          checks     = 0;
  int          errors     = 0;
  int          cyc        = 0;
  logic [7:0]  sb_q[$];
  logic        mon_en     = 1'b0;
  logic        gap_en     = 1'b0;
  logic        prev_valid = 1'b0;
  int          prev_start = 0;

  uart_tx_slave #(
    .CLKDIV    (CLKDIV),
    .FIFODEPTH (FIFODEPTH),
    .BASEADDR  (BASEADDR)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .busaddr  (busaddr),
    .busdataw (busdataw),
    .buswrite (buswrite),
    .busdatar (busdatar),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called just after a falling edge; returns after the next falling edge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    busaddr  = addr;
    busdataw = data;
    buswrite = 1'b1;
    @(negedge clk);
    buswrite = 1'b0;
    busaddr  = STATUS_A;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    busaddr = addr;
    #1;
    check_eq(tag, busdatar, exp);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    check_eq("drain", sb_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic count_lows(input string tag, input int ncyc);
    int lows;
    lows = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check_eq(tag, lows, 0);
  endtask

  // Serial monitor: samples mid-bit and scores each complete frame
  initial begin : monitor
    logic [7:0] b;
    int         st;
    b = '0;
    forever begin
      @(negedge clk);
      if (mon_en && nrst && txd === 1'b0) begin
        st = cyc;
        if (gap_en && prev_valid) check_eq("frame_gap", st - prev_start, FRAME);
        prev_start = st;
        prev_valid = 1'b1;
        repeat (CLKDIV / 2) @(negedge clk);
        check_eq("start_bit", {31'h0, txd}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKDIV) @(negedge clk);
          b[i] = txd;
        end
        repeat (CLKDIV) @(negedge clk);
        check_eq("stop_bit", {31'h0, txd}, 32'h1);
        if (sb_q.size() > 0) check_eq("frame_byte", {23'h0, 1'b1, b}, {23'h0, 1'b1, sb_q.pop_front()});
        else                 check_eq("frame_byte", {23'h0, 1'b1, b}, 32'h0);
      end
    end
  end

  initial begin : stim
    logic [7:0] t3 [5];
    logic [7:0] t4 [6];
    t3 = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A};
    t4 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_txd", {31'h0, txd}, 32'h1);
    read_check("rst_status", STATUS_A, 32'h2);
    read_check("rst_txdata", BASEADDR, 32'h0);
    nrst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Single frame latency, busy flag and serial pattern
    sb_q.push_back(8'hA5);
    bus_write(BASEADDR, 32'hA5);
    check_eq("lat_e0_txd", {31'h0, txd}, 32'h1);
    @(negedge clk);
    check_eq("lat_e1_txd", {31'h0, txd}, 32'h0);
    repeat (20) @(negedge clk);
    read_check("busy_mid", STATUS_A, 32'h6);
    repeat (20) @(negedge clk);
    read_check("idle_after", STATUS_A, 32'h2);
    check_eq("sb_after_a5", sb_q.size(), 0);

    // Five consecutive writes: no drop, back-to-back frames
    prev_valid = 1'b0;
    gap_en     = 1'b1;
    busaddr    = BASEADDR;
    buswrite   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      busdataw = {24'h0, t3[i]};
      sb_q.push_back(t3[i]);
      @(negedge clk);
    end
    buswrite = 1'b0;
    read_check("t3_status", STATUS_A, 32'h45);
    wait_drain(6 * FRAME);
    gap_en = 1'b0;
    read_check("t3_idle", STATUS_A, 32'h2);

    // Overflow on a sixth write while a frame is in flight, then clear it
    busaddr  = BASEADDR;
    buswrite = 1'b1;
    for (int i = 0; i < 6; i++) begin
      busdataw = {24'h0, t4[i]};
      if (i < 5) sb_q.push_back(t4[i]);
      @(negedge clk);
    end
    buswrite = 1'b0;
    read_check("t4_ovf", STATUS_A, 32'h4D);
    bus_write(STATUS_A, 32'hFFFF_FFF7);
    read_check("t4_noclr", STATUS_A, 32'h4D);
    bus_write(STATUS_A, 32'h8);
    read_check("t4_clr", STATUS_A, 32'h45);
    wait_drain(6 * FRAME);
    read_check("t4_idle", STATUS_A, 32'h2);

    // Writes to unmapped addresses are ignored
    bus_write(BASEADDR + 32'h8, 32'h55);
    bus_write(32'h0, 32'h66);
    count_lows("t5_txd_idle", 12);
    read_check("t5_status", STATUS_A, 32'h2);
    read_check("t5_rd108", BASEADDR + 32'h8, 32'h0);

    // Reset in the middle of data bit 3 abandons the frame
    mon_en = 1'b0;
    bus_write(BASEADDR, 32'hC3);
    @(negedge clk);
    repeat (18) @(negedge clk);
    check_eq("t6_bit3_low", {31'h0, txd}, 32'h0);
    nrst = 1'b0;
    #1;
    check_eq("t6_txd_async", {31'h0, txd}, 32'h1);
    read_check("t6_status_rst", STATUS_A, 32'h2);
    @(negedge clk);
    nrst = 1'b1;
    read_check("t6_status_rel", STATUS_A, 32'h2);
    count_lows("t6_no_resume", 2 * FRAME);
    mon_en = 1'b1;

    // Normal operation resumes after reset
    sb_q.push_back(8'h81);
    bus_write(BASEADDR, 32'h81);
    wait_drain(2 * FRAME);
    read_check("t6_final", STATUS_A, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
